// File: rtl/tick_generator.sv
// tick_generator: multi-channel programmable tick source with per-channel square wave.
//
// Each channel counts clk cycles (or, when TICK_CASCADE_EN is defined, ticks of
// the previous channel) up to its runtime-programmable period, producing a
// registered one-cycle tick pulse and a 50 % duty square wave that toggles on
// every tick.
//
// Optional feature macro: TICK_CASCADE_EN
//   defined   : channel i>0 steps on tick_o[i-1]; channel 0 steps every cycle
//   undefined : every channel steps every cycle
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   global count enable
//   clr        in   synchronous restart of all channels
//   cfg_we     in   period write strobe
//   cfg_ch     in   channel selected for write / readback
//   cfg_period in   new period in cycles (0 parks the channel)
//   cfg_rdata  out  period of cfg_ch, combinational; 0 for out-of-range cfg_ch
//   tick_o     out  one-cycle pulse per channel period
//   sq_o       out  square wave toggling on each channel tick
module tick_generator #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 27,
    parameter int unsigned DEFAULT_PERIOD = 100000000,
    localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic [CNT_W-1:0]  cfg_rdata,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o
);

    logic [CNT_W-1:0]  period_v [NUM_CH];
    logic [NUM_CH-1:0] step;

`ifdef TICK_CASCADE_EN
    // Channel i advances once per tick of channel i-1, so a parked upstream
    // channel freezes everything downstream of it.
    if (NUM_CH > 1) begin : g_cascade
        assign step = {tick_o[NUM_CH-2:0], 1'b1};
    end else begin : g_single
        assign step = 1'b1;
    end
`else
    assign step = '1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             sel;
        logic             wrap;

        assign sel  = cfg_we && (cfg_ch == CH_W'(i));
        assign wrap = (cnt_q == period_q - CNT_W'(1));

        // Priority: clr, own period write, parked, stalled, wrap, count.
        // A write coincident with clr still lands in the period register.
        always_comb begin
            period_d = sel ? cfg_period : period_q;
            cnt_d    = cnt_q;
            tick_d   = 1'b0;
            sq_d     = sq_q;
            if (clr) begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (sel) begin
                cnt_d = '0;
            end else if (period_q == '0) begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (en && step[i]) begin
                cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
                tick_d = wrap;
                sq_d   = wrap ? ~sq_q : sq_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period_q <= CNT_W'(DEFAULT_PERIOD);
                cnt_q    <= '0;
                tick_q   <= 1'b0;
                sq_q     <= 1'b0;
            end else begin
                period_q <= period_d;
                cnt_q    <= cnt_d;
                tick_q   <= tick_d;
                sq_q     <= sq_d;
            end
        end

        assign period_v[i] = period_q;
        assign tick_o[i]   = tick_q;
        assign sq_o[i]     = sq_q;
    end

    // Decoded readback so an out-of-range cfg_ch returns 0 rather than
    // indexing past the array.
    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i))
                cfg_rdata = period_v[i];
    end

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed self-checking bench for tick_generator.
module tb_tick_generator;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_rdata;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] sq_o;

    int n_tests = 0;
    int n_fail  = 0;

    tick_generator #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_PERIOD(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .clr(clr),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_rdata(cfg_rdata),
        .tick_o(tick_o),
        .sq_o(sq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] p);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        edges(1);
        cfg_we     = 1'b0;
    endtask

    task automatic readback(input string tag, input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] exp);
        cfg_ch = ch;
        #1;
        check(tag, 32'(cfg_rdata), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        #12;
        check("rst_tick", 32'(tick_o), 0);
        check("rst_sq", 32'(sq_o), 0);
        readback("rst_rdata", 0, 10);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifndef TICK_CASCADE_EN
        // Free run at P=10: ticks after edges 10, 20, 30; sq 1,0,1.
        for (int e = 1; e <= 30; e++) begin
            edges(1);
            check("run_tick", 32'(tick_o), (e % 10 == 0) ? 32'h7 : 32'h0);
            check("run_sq", 32'(sq_o), ((e / 10) % 2 == 1) ? 32'h7 : 32'h0);
        end

        // Rewrite ch1 to P=3 while its count sits at 6.
        edges(6);
        write(1, 3);
        check("wr_edge_tick", 32'(tick_o), 0);
        check("wr_edge_sq1", 32'(sq_o[1]), 1);
        for (int k = 1; k <= 12; k++) begin
            edges(1);
            check("wr_tick0", 32'(tick_o[0]), (k == 3) ? 1 : 0);
            check("wr_tick2", 32'(tick_o[2]), (k == 3) ? 1 : 0);
            check("wr_tick1", 32'(tick_o[1]), (k % 3 == 0) ? 1 : 0);
            check("wr_sq1", 32'(sq_o[1]), ((k / 3) % 2 == 1) ? 0 : 1);
            check("wr_sq0", 32'(sq_o[0]), (k >= 3) ? 0 : 1);
        end
        readback("rd_ch1", 1, 3);
        readback("rd_ch0", 0, 10);
        write(3, 5);
        readback("rd_bad", 3, 0);
        readback("rd_ch0_kept", 0, 10);
        readback("rd_ch1_kept", 1, 3);
        readback("rd_ch2_kept", 2, 10);

        // Enable stall: en low for edges 5..9 holds count at 4, tick at 15.
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        check("clr_tick", 32'(tick_o), 0);
        check("clr_sq", 32'(sq_o), 0);
        for (int e = 1; e <= 16; e++) begin
            if (e == 5) en = 1'b0;
            if (e == 10) en = 1'b1;
            edges(1);
            check("en_tick0", 32'(tick_o[0]), (e == 15) ? 1 : 0);
            check("en_tick2", 32'(tick_o[2]), (e == 15) ? 1 : 0);
            check("en_sq0", 32'(sq_o[0]), (e >= 15) ? 1 : 0);
        end

        // Park ch2 (P=0): sq holds on the write edge, then forced low.
        write(2, 0);
        check("park_tick_wr", 32'(tick_o[2]), 0);
        check("park_sq_wr", 32'(sq_o[2]), 1);
        for (int k = 2; k <= 8; k++) begin
            edges(1);
            check("park_tick", 32'(tick_o[2]), 0);
            check("park_sq", 32'(sq_o[2]), 0);
        end

        // P=1: tick held high, sq toggles every cycle.
        write(2, 1);
        check("p1_tick_wr", 32'(tick_o[2]), 0);
        check("p1_sq_wr", 32'(sq_o[2]), 0);
        for (int k = 2; k <= 7; k++) begin
            edges(1);
            check("p1_tick", 32'(tick_o[2]), 1);
            check("p1_sq", 32'(sq_o[2]), 32'((k - 1) % 2));
        end

        // clr lands exactly on cnt==P-1 of ch0, together with a ch1 write.
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        edges(10);
        check("pre_tick0", 32'(tick_o[0]), 1);
        check("pre_sq0", 32'(sq_o[0]), 1);
        edges(9);
        check("pre2_tick0", 32'(tick_o[0]), 0);
        check("pre2_sq0", 32'(sq_o[0]), 1);
        clr = 1'b1; cfg_we = 1'b1; cfg_ch = 1; cfg_period = 4;
        edges(1);
        clr = 1'b0; cfg_we = 1'b0;
        check("clrw_tick", 32'(tick_o), 0);
        check("clrw_sq", 32'(sq_o), 0);
        readback("clrw_rd1", 1, 4);
        for (int k = 1; k <= 10; k++) begin
            edges(1);
            check("clrw_tick0", 32'(tick_o[0]), (k == 10) ? 1 : 0);
            check("clrw_tick1", 32'(tick_o[1]), (k % 4 == 0) ? 1 : 0);
        end

        // Async reset between edges: outputs and periods revert at once.
        check("ar_pre_tick2", 32'(tick_o[2]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tick", 32'(tick_o), 0);
        check("ar_sq", 32'(sq_o), 0);
        readback("ar_rd2", 2, 10);
        readback("ar_rd1", 1, 10);
        rst_n = 1'b1;
        edges(1);
`else
        // Cascade P0=4, P1=3: after clr ch1 ticks at edges 13, 25, 37, 49.
        write(0, 4);
        write(1, 3);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            edges(1);
            check("cas_tick0", 32'(tick_o[0]), (k % 4 == 0) ? 1 : 0);
            check("cas_tick1", 32'(tick_o[1]), (k > 1 && k % 12 == 1) ? 1 : 0);
        end
        write(0, 0);
        for (int k = 1; k <= 30; k++) begin
            edges(1);
            check("cas_park1", 32'(tick_o[1:0]), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
